// File: rtl/parity_frame_checker.sv
`default_nettype none
// ============================================================================
// Module   : parity_frame_checker
// Brief    : Receive side of the parity-frame serial link. Collects DATA_W
//            data bits (LSB first) and one parity bit, then presents the
//            word with a parity-error flag. Also keeps a saturating error
//            counter and a sticky error flag for status readback.
// Revision : 1.0  initial release
// ============================================================================
module parity_frame_checker #(
    parameter int DATA_W = 4,   // data bits per frame (>= 2); frame is DATA_W+1 bits
    parameter int CNT_W  = 8    // error counter width
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sin_valid,
    input  logic              sin_bit,
    input  logic              sin_sof,
    input  logic              err_clr,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_perr,
    output logic              resync,
    output logic [CNT_W-1:0]  err_cnt,
    output logic              err_sticky
);

    // Bit counter must be able to hold DATA_W (the "expect parity" position).
    localparam int              CW        = $clog2(DATA_W + 1);
    localparam logic [CW-1:0]   C_ONE     = CW'(1);
    localparam logic [CW-1:0]   C_LAST    = CW'(DATA_W);
    localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t              state_q;
    logic [CW-1:0]       bitcnt_q;
    logic [DATA_W-1:0]   shift_q;
    logic                out_valid_q;
    logic [DATA_W-1:0]   out_data_q;
    logic                out_perr_q;
    logic                resync_q;
    logic [CNT_W-1:0]    err_cnt_q;
    logic                err_sticky_q;

    logic [DATA_W-1:0]   shift_d;
    logic                perr_d;
    logic                done_d;
    logic [CNT_W-1:0]    err_cnt_d;
    logic                err_sticky_d;

    // Next-state helpers: LSB-first shift, frame parity, completion and error status.
    always_comb begin
        // Shifting in at the top leaves d[0] in bit 0 once DATA_W bits are in.
        shift_d      = {sin_bit, shift_q[DATA_W-1:1]};
        // While the parity bit is on the line, shift_q holds the full data word.
        perr_d       = ^{sin_bit, shift_q};
        done_d       = sin_valid && !sin_sof && (state_q == SHIFT) && (bitcnt_q == C_LAST);
        err_cnt_d    = err_cnt_q;
        err_sticky_d = err_sticky_q;
        if (err_clr) begin
            // Clear wins over an error completing in the same cycle.
            err_cnt_d    = '0;
            err_sticky_d = 1'b0;
        end else if (done_d && perr_d) begin
            err_sticky_d = 1'b1;
            if (err_cnt_q != C_CNT_MAX) begin
                err_cnt_d = err_cnt_q + 1'b1;
            end
        end
    end

    // Framing FSM with registered word, pulse and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            bitcnt_q     <= '0;
            shift_q      <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_perr_q   <= 1'b0;
            resync_q     <= 1'b0;
            err_cnt_q    <= '0;
            err_sticky_q <= 1'b0;
        end else begin
            out_valid_q  <= done_d;
            resync_q     <= 1'b0;
            err_cnt_q    <= err_cnt_d;
            err_sticky_q <= err_sticky_d;
            if (sin_valid) begin
                case (state_q)
                    IDLE: begin
                        // Bits outside a frame are dropped until a start bit shows up.
                        if (sin_sof) begin
                            shift_q  <= shift_d;
                            bitcnt_q <= C_ONE;
                            state_q  <= SHIFT;
                        end
                    end
                    SHIFT: begin
                        if (sin_sof) begin
                            // New start bit mid-frame: abandon the partial frame
                            // silently (no word, no error) and begin again.
                            resync_q <= 1'b1;
                            shift_q  <= shift_d;
                            bitcnt_q <= C_ONE;
                        end else if (bitcnt_q == C_LAST) begin
                            out_data_q <= shift_q;
                            out_perr_q <= perr_d;
                            bitcnt_q   <= '0;
                            state_q    <= IDLE;
                        end else begin
                            shift_q  <= shift_d;
                            bitcnt_q <= bitcnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_q  <= IDLE;
                        bitcnt_q <= '0;
                    end
                endcase
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_perr   = out_perr_q;
    assign resync     = resync_q;
    assign err_cnt    = err_cnt_q;
    assign err_sticky = err_sticky_q;

endmodule
`default_nettype wire

// File: tb/tb_parity_frame_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_parity_frame_checker
// Brief    : Self-checking bench for parity_frame_checker. A frame-level
//            model (list of collected bits) predicts every output each
//            cycle; directed sequences pin literal values. Two instances
//            share stimulus: default counter width and a 2-bit counter.
// Revision : 1.0  initial release
// ============================================================================
module tb_parity_frame_checker;

    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sin_valid = 1'b0;
    logic          sin_bit = 1'b0;
    logic          sin_sof = 1'b0;
    logic          err_clr = 1'b0;

    logic          out_valid, out_perr, resync, err_sticky;
    logic [DW-1:0] out_data;
    logic [7:0]    err_cnt;
    logic          out_valid2, out_perr2, resync2, err_sticky2;
    logic [DW-1:0] out_data2;
    logic [1:0]    err_cnt2;

    int tests = 0;
    int fails = 0;
    int nvalid = 0;
    int nresync = 0;

    parity_frame_checker #(.DATA_W(DW), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .sin_valid(sin_valid), .sin_bit(sin_bit),
        .sin_sof(sin_sof), .err_clr(err_clr), .out_valid(out_valid),
        .out_data(out_data), .out_perr(out_perr), .resync(resync),
        .err_cnt(err_cnt), .err_sticky(err_sticky)
    );

    parity_frame_checker #(.DATA_W(DW), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .sin_valid(sin_valid), .sin_bit(sin_bit),
        .sin_sof(sin_sof), .err_clr(err_clr), .out_valid(out_valid2),
        .out_data(out_data2), .out_perr(out_perr2), .resync(resync2),
        .err_cnt(err_cnt2), .err_sticky(err_sticky2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Frame is a list of bits collected so far; nbits==0 means not in a frame.
    int            nbits = 0;
    logic [7:0]    fbits = '0;
    logic          exp_valid = 1'b0, exp_perr = 1'b0, exp_resync = 1'b0, exp_sticky = 1'b0;
    logic [DW-1:0] exp_data = '0;
    int            exp_cnt8 = 0, exp_cnt2 = 0;

    always @(posedge clk or posedge rst) begin
        logic done;
        logic bad;
        done = 1'b0;
        bad  = 1'b0;
        if (rst) begin
            nbits = 0; fbits = '0;
            exp_valid = 0; exp_perr = 0; exp_resync = 0; exp_sticky = 0;
            exp_data = '0; exp_cnt8 = 0; exp_cnt2 = 0;
        end else begin
            exp_valid  = 1'b0;
            exp_resync = 1'b0;
            if (sin_valid) begin
                if (sin_sof) begin
                    if (nbits > 0) exp_resync = 1'b1;
                    fbits = '0;
                    fbits[0] = sin_bit;
                    nbits = 1;
                end else if (nbits > 0) begin
                    fbits[nbits] = sin_bit;
                    nbits++;
                    if (nbits == DW + 1) begin
                        done = 1'b1;
                        bad  = ($countones(fbits[DW:0]) % 2) == 1;
                        exp_valid = 1'b1;
                        exp_data  = fbits[DW-1:0];
                        exp_perr  = bad;
                        nbits = 0;
                    end
                end
            end
            if (err_clr) begin
                exp_cnt8 = 0; exp_cnt2 = 0; exp_sticky = 1'b0;
            end else if (done && bad) begin
                exp_sticky = 1'b1;
                exp_cnt8 = (exp_cnt8 < 255) ? exp_cnt8 + 1 : 255;
                exp_cnt2 = (exp_cnt2 < 3) ? exp_cnt2 + 1 : 3;
            end
        end
    end

    // Cycle-by-cycle comparison, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            chk("out_valid", 32'(out_valid), 32'(exp_valid));
            chk("resync", 32'(resync), 32'(exp_resync));
            chk("out_data", 32'(out_data), 32'(exp_data));
            chk("out_perr", 32'(out_perr), 32'(exp_perr));
            chk("err_cnt", 32'(err_cnt), 32'(exp_cnt8));
            chk("err_sticky", 32'(err_sticky), 32'(exp_sticky));
            chk("err_cnt_w2", 32'(err_cnt2), 32'(exp_cnt2));
            chk("err_sticky_w2", 32'(err_sticky2), 32'(exp_sticky));
            if (out_valid) nvalid++;
            if (resync) nresync++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic v, input logic b, input logic s, input logic c);
        sin_valid = v; sin_bit = b; sin_sof = s; err_clr = c;
        @(posedge clk);
        #1;
    endtask

    // Sends d[0..DW-1] then p, with 'gap' idle cycles between bits; returns
    // just after the edge that accepted p, so out_valid is high.
    task automatic send_frame(input logic [DW-1:0] d, input logic p, input int gap, input logic clr_on_p);
        for (int i = 0; i < DW; i++) begin
            cyc(1'b1, d[i], (i == 0), 1'b0);
            for (int g = 0; g < gap; g++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        end
        cyc(1'b1, p, 1'b0, clr_on_p);
    endtask

    initial begin
        int v0, r0;
        logic [1:0] sat_tbl [5];
        sat_tbl = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        chk("rst_sticky", 32'(err_sticky), 32'd0);
        rst = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);

        // Good frame 1,1,0,1 p=1
        send_frame(4'b1011, 1'b1, 0, 1'b0);
        chk("f1_valid", 32'(out_valid), 32'd1);
        chk("f1_data", 32'(out_data), 32'hb);
        chk("f1_perr", 32'(out_perr), 32'd0);
        chk("f1_cnt", 32'(err_cnt), 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("f1_pulse_len", 32'(out_valid), 32'd0);

        // Bad frame 0,0,0,0 p=1, then clear
        send_frame(4'b0000, 1'b1, 0, 1'b0);
        chk("f2_data", 32'(out_data), 32'h0);
        chk("f2_perr", 32'(out_perr), 32'd1);
        chk("f2_cnt", 32'(err_cnt), 32'd1);
        chk("f2_sticky", 32'(err_sticky), 32'd1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("clr_cnt", 32'(err_cnt), 32'd0);
        chk("clr_sticky", 32'(err_sticky), 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);

        // Gapped frame 1,0,1,0 p=0
        v0 = nvalid;
        send_frame(4'b0101, 1'b0, 3, 1'b0);
        chk("gap_data", 32'(out_data), 32'h5);
        chk("gap_perr", 32'(out_perr), 32'd0);
        repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("gap_pulses", 32'(nvalid - v0), 32'd1);

        // Resync: two bits of a frame, then a fresh frame 1,0,0,1 p=0
        v0 = nvalid; r0 = nresync;
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        send_frame(4'b1001, 1'b0, 0, 1'b0);
        chk("rs_data", 32'(out_data), 32'h9);
        chk("rs_perr", 32'(out_perr), 32'd0);
        chk("rs_cnt", 32'(err_cnt), 32'd0);
        repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("rs_resync_pulses", 32'(nresync - r0), 32'd1);
        chk("rs_valid_pulses", 32'(nvalid - v0), 32'd1);

        // Stray bits while idle, then a frame
        v0 = nvalid;
        repeat (3) cyc(1'b1, 1'b1, 1'b0, 1'b0);
        send_frame(4'b0110, 1'b0, 0, 1'b0);
        chk("stray_data", 32'(out_data), 32'h6);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("stray_pulses", 32'(nvalid - v0), 32'd1);

        // Async reset after 3 bits of a frame
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        sin_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("mrst_data", 32'(out_data), 32'd0);
        chk("mrst_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        v0 = nvalid; r0 = nresync;
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("mrst_no_valid", 32'(nvalid - v0), 32'd0);
        chk("mrst_no_resync", 32'(nresync - r0), 32'd0);

        // Saturation on the 2-bit counter: five bad frames back to back
        for (int k = 0; k < 5; k++) begin
            send_frame(4'b0001, 1'b0, 0, 1'b0);
            chk("sat_cnt_w2", 32'(err_cnt2), 32'(sat_tbl[k]));
        end
        chk("sat_cnt_w8", 32'(err_cnt), 32'd5);
        send_frame(4'b0001, 1'b0, 0, 1'b1);
        chk("sat_clr_w2", 32'(err_cnt2), 32'd0);
        chk("sat_clr_w8", 32'(err_cnt), 32'd0);
        chk("sat_clr_perr", 32'(out_perr), 32'd1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);

        // Randomized traffic checked by the model every cycle
        for (int n = 0; n < 3000; n++) begin
            cyc(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 63) == 0));
        end
        repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
